// File: rtl/tca_pkg.sv
// tca_pkg: definitions shared across the time-correlation analyser.
//   - Command codes for the cmd port.
//   - Default histogram address width. The histogram memory uses the same value.
//   - Encoding of the binner FSM states.
package tca_pkg;

  localparam logic [1:0] CMD_NOP   = 2'b00;
  localparam logic [1:0] CMD_CLEAR = 2'b01;
  localparam logic [1:0] CMD_RUN   = 2'b10;

  localparam int TCA_ADDR_WIDTH = 7;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ARMED  = 2'b01,
    ST_WINDOW = 2'b10
  } tca_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// sync_edge_detect: brings an asynchronous pulse into the clk domain through a
// 2-FF synchroniser, then turns each rising edge into a registered one-cycle
// pulse. The pulse appears 3 cycles after the input rises.
//   clk      in  system clock
//   rst_n    in  asynchronous active-low reset
//   async_in in  asynchronous input; only its rising edge is significant
//   pulse    out one-cycle rising-edge pulse, registered
module sync_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic pulse
);

  logic meta_p0;
  logic sync_p1;
  logic sync_p2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      // stage p0: first synchroniser flop, may go metastable
      meta_p0 <= async_in;
      // stage p1: second synchroniser flop
      sync_p1 <= meta_p0;
      // stage p2: delayed copy of the synchronised input, used for edge detection
      sync_p2 <= sync_p1;
      pulse   <= sync_p1 & ~sync_p2;
    end
  end

endmodule

// File: rtl/photon_delay_binner.sv
// photon_delay_binner: measures the delay, in clock cycles, from the most
// recent start pulse to each photon pulse. The delay is quantised into
// 2^ADDR_WIDTH bins, and each bin index is queued in a small FIFO for the
// histogram memory.
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   cmd          in  00 nop, 01 stop/clear, 10 run, 11 nop
//   start_in     in  asynchronous start pulse (rising edge)
//   photon_in    in  asynchronous SPAD pulse (rising edge)
//   bin_addr     out head-of-FIFO bin index
//   bin_valid    out FIFO non-empty
//   bin_ready    in  consumer takes the head entry this cycle
//   busy         out FSM not in IDLE
//   overflow_cnt out photons dropped on a full FIFO (saturating)
module photon_delay_binner
  import tca_pkg::*;
#(
  parameter int ADDR_WIDTH = TCA_ADDR_WIDTH,
  parameter int BIN_SHIFT  = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int DEAD_TIME  = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            cmd,
  input  logic                  start_in,
  input  logic                  photon_in,
  output logic [ADDR_WIDTH-1:0] bin_addr,
  output logic                  bin_valid,
  input  logic                  bin_ready,
  output logic                  busy,
  output logic [15:0]           overflow_cnt
);

  localparam int CNT_W  = ADDR_WIDTH + BIN_SHIFT;
  localparam int PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int DEAD_W = (DEAD_TIME > 0) ? $clog2(DEAD_TIME + 1) : 1;

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  logic start_pulse;
  logic photon_pulse;

  sync_edge_detect u_start_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (start_in),
    .pulse    (start_pulse)
  );

  sync_edge_detect u_photon_sync (
    .clk      (clk),
    .rst_n    (rst_n),
    .async_in (photon_in),
    .pulse    (photon_pulse)
  );

  tca_state_e              state;
  logic [CNT_W-1:0]        delay_cnt;
  logic [DEAD_W-1:0]       dead_cnt;
  logic                    clear;
  logic                    run;
  logic                    accept;
  logic [ADDR_WIDTH-1:0]   push_bin;

  assign clear = (cmd == CMD_CLEAR);
  assign run   = (cmd == CMD_RUN);

  // The photon is binned with the counter value it sees this cycle. On a
  // same-cycle start, that is the pre-restart value. On the terminal cycle,
  // that is the last bin.
  assign accept   = (state == ST_WINDOW) && photon_pulse && (dead_cnt == '0) && !clear;
  assign push_bin = delay_cnt[CNT_W-1:BIN_SHIFT];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      delay_cnt <= '0;
    end else if (clear) begin
      state <= ST_IDLE;
      busy  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (run) begin
            state <= ST_ARMED;
            busy  <= 1'b1;
          end
        end
        ST_ARMED: begin
          if (start_pulse) begin
            delay_cnt <= '0;
            state     <= ST_WINDOW;
          end
        end
        ST_WINDOW: begin
          if (start_pulse) begin
            delay_cnt <= '0;
          end else if (delay_cnt == '1) begin
            state <= ST_ARMED;
          end else begin
            delay_cnt <= delay_cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Dead time is independent of the FSM, so it carries across restarts and
  // window boundaries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dead_cnt <= '0;
    end else if (clear) begin
      dead_cnt <= '0;
    end else if (accept) begin
      dead_cnt <= DEAD_W'(DEAD_TIME);
    end else if (dead_cnt != '0) begin
      dead_cnt <= dead_cnt - DEAD_W'(1);
    end
  end

  logic [ADDR_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [FCNT_W-1:0]     fifo_count;
  logic                  pop;
  logic                  full;
  logic                  push_ok;
  logic                  drop;
  logic [PTR_W-1:0]      wr_ptr_n;
  logic [PTR_W-1:0]      rd_ptr_n;
  logic [FCNT_W-1:0]     count_n;
  logic [ADDR_WIDTH-1:0] head_n;

  assign pop     = bin_valid && bin_ready;
  assign full    = (fifo_count == FCNT_W'(FIFO_DEPTH));
  assign push_ok = accept && (!full || pop);
  assign drop    = accept && full && !pop;

  // The next head is computed ahead of time, so bin_addr/bin_valid can be
  // registered. A push into a FIFO that will be empty after this cycle's pop
  // becomes the head directly.
  always_comb begin
    wr_ptr_n = wr_ptr + PTR_W'(push_ok);
    rd_ptr_n = rd_ptr + PTR_W'(pop);
    count_n  = fifo_count + FCNT_W'(push_ok) - FCNT_W'(pop);
    head_n   = '0;
    if (count_n != '0) begin
      if (push_ok && (wr_ptr == rd_ptr_n)) begin
        head_n = push_bin;
      end else begin
        head_n = mem[rd_ptr_n];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_bin;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      bin_valid    <= 1'b0;
      bin_addr     <= '0;
      overflow_cnt <= '0;
    end else if (clear) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      fifo_count   <= '0;
      bin_valid    <= 1'b0;
      bin_addr     <= '0;
      overflow_cnt <= '0;
    end else begin
      wr_ptr     <= wr_ptr_n;
      rd_ptr     <= rd_ptr_n;
      fifo_count <= count_n;
      bin_valid  <= (count_n != '0);
      bin_addr   <= head_n;
      if (drop) begin
        overflow_cnt <= sat_inc16(overflow_cnt);
      end
    end
  end

endmodule

// File: doc/photon_delay_binner.md
# photon_delay_binner

Converts start/photon edge pairs into histogram bin addresses for the time-correlation analyser. Two asynchronous pulse inputs are synchronised: the pattern/laser sync (start) and the SPAD detector output (photon). The block measures each photon's delay after the most recent start in clock cycles, quantises it into 2^ADDR_WIDTH bins, and hands the bin index through a small FIFO to the downstream histogram memory, which increments that bin.

## Interface
- ADDR_WIDTH, 7: bin index width; 128 bins.
- BIN_SHIFT, 2: cycles per bin = 2^BIN_SHIFT.
- FIFO_DEPTH, 4: bin FIFO entries; power of two.
- DEAD_TIME, 8: cycles after an accepted photon during which photon edges are ignored.
- clk  in  1  system clock.
- rst_n  in  1  reset; asynchronous and active-low.
- cmd  in  2  command, sampled every cycle: 00 nop, 01 stop/clear, 10 run, 11 nop (reserved).
- start_in  in  1  asynchronous start pulse, rising-edge significant.
- photon_in  in  1  asynchronous SPAD pulse, rising-edge significant.
- bin_addr  out  ADDR_WIDTH  head-of-FIFO bin index.
- bin_valid  out  1  FIFO non-empty.
- bin_ready  in  1  consumer accepts the head entry this cycle.
- busy  out  1  state is not IDLE.
- overflow_cnt  out  16  photons dropped on a full FIFO; saturates at 0xFFFF.

## Operation
- Each of start_in and photon_in has a 2-FF synchroniser plus a rising-edge register. This produces a 1-cycle edge pulse 3 cycles after the input rises.
- The delay counter is ADDR_WIDTH+BIN_SHIFT bits wide (9 bits by default). The bin is the counter's top ADDR_WIDTH bits, i.e. counter >> BIN_SHIFT.
- FSM states: IDLE, ARMED, WINDOW.
  - IDLE: cmd=10 moves to ARMED. All edges are ignored.
  - ARMED: a start pulse clears the counter to 0 and moves to WINDOW. Photon pulses are ignored.
  - WINDOW: the counter increments every cycle.
    - A start pulse restarts the counter at 0 and the FSM stays in WINDOW.
    - At terminal count (all ones) the FSM moves to ARMED.
  - cmd=01 in any state: the FSM goes to IDLE, the FIFO is flushed, the dead-time counter is cleared, and overflow_cnt is cleared. cmd=01 takes priority over every other event.
- Photon acceptance: a photon pulse in WINDOW with the dead-time counter at zero pushes the bin of the current counter value and loads the dead-time counter with DEAD_TIME.
  - The dead-time counter decrements to 0.
  - Dead time spans start restarts and windows.
- Simultaneous start and photon in WINDOW: the photon is binned with the pre-restart counter value, then the counter restarts.
- Photon on the terminal-count cycle: it is binned into the last bin (127), then the FSM moves to ARMED.
- FIFO:
  - Pop when bin_valid && bin_ready.
  - Push while full with no pop: the entry is dropped and overflow_cnt increments, saturating.
  - Push while full with a same-cycle pop: the push is accepted.
  - Push and pop on an empty FIFO are not bypassed. The entry becomes visible the next cycle.

## Timing
- Reset values: bin_addr 0, bin_valid 0, busy 0, overflow_cnt 0, FSM IDLE, FIFO empty, counters 0, synchroniser flops 0.
- Start pulse in cycle S: counter = 0 in cycle S+1.
- Photon pulse in cycle P with S < P: bin = (P−S−1) >> BIN_SHIFT. Equal input rise-to-rise delay d gives bin = (d−1) >> BIN_SHIFT.
- Latency from photon_in rise to bin_valid with an empty FIFO: 4 cycles.
- bin_addr/bin_valid are registered and stable while bin_valid && !bin_ready.
- busy rises the cycle after cmd=10 is sampled in IDLE. It falls the cycle after cmd=01 is sampled.
- Asserting rst_n mid-window returns everything to reset values immediately. Nothing resumes until a new cmd=10.
- Pulses shorter than 1 clock period are not guaranteed to be seen. The input high and low phases must each be ≥ 2 clk periods.

## Structure
- Shared package (tca_pkg) holds:
  - command codes CMD_NOP=2'b00, CMD_CLEAR=2'b01, CMD_RUN=2'b10;
  - the default ADDR_WIDTH=7, shared with the histogram memory;
  - the FSM state encoding.
- One sub-module, sync_edge_detect: 2-FF synchroniser plus rising-edge pulse, instantiated for start and photon.
- The FIFO stays inline as a register array with pointers and a count.

## Test plan
- cmd=10, start rise, photon rise 41 cycles later, bin_ready=1 -> one bin_valid beat with bin_addr=10, 4 cycles after the photon rise; overflow_cnt=0.
- Start, then photons at delays 1 and 512 -> bins 0 and 127 delivered.
  - A photon at delay 514 after the window closes is ignored.
  - A second start re-arms the block.
- Photons at delays 20 and 24 with DEAD_TIME=8 -> only bin 4 pushed. A photon at delay 40 -> bin 9 pushed.
- Start and photon rising on the same cycle, 101 cycles after a prior start -> bin 25; the counter restarts, and a photon 9 cycles later gives bin 2.
- bin_ready=0, six spaced accepted photons -> FIFO holds the first four in order and overflow_cnt=2. Raising bin_ready drains all four in order.
- cmd=01 mid-window with 3 queued entries -> the next cycle bin_valid=0, busy=0, overflow_cnt=0, and photons are ignored. rst_n low mid-window -> all outputs immediately at reset values.
